// File: rtl/regfile_bypass.sv
// regfile_bypass: 32 x 32-bit RV32I register file with two combinational
// read ports, one write-back port with write-first bypass, and a debug
// request/acknowledge port that borrows the write port when write-back is idle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no debug transaction; a held dbg_req_i is latched here
// BUSY  | latched debug access pending; writes wait while write-back writes
// ACK   | access done, dbg_ack_o high for this one cycle, dbg_req_i ignored
module regfile_bypass #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] reg1_raddr_i,
   input  logic                  reg1_re_i,
   output logic [DATA_WIDTH-1:0] reg1_rdata_o,
   input  logic [ADDR_WIDTH-1:0] reg2_raddr_i,
   input  logic                  reg2_re_i,
   output logic [DATA_WIDTH-1:0] reg2_rdata_o,
   input  logic                  reg_we_i,
   input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
   input  logic [DATA_WIDTH-1:0] reg_wdata_i,
   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   output logic                  dbg_ack_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o
);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} dbg_state_t;

   dbg_state_t            state;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  dbg_we_q;
   logic [ADDR_WIDTH-1:0] dbg_addr_q;
   logic [DATA_WIDTH-1:0] dbg_wdata_q;
   logic                  wb_write;
   logic                  dbg_write;

   // Writes to x0 are dropped, so they never count as write-back activity.
   assign wb_write  = reg_we_i && (reg_waddr_i != '0);
   assign dbg_write = (state == BUSY) && dbg_we_q && !wb_write && (dbg_addr_q != '0);

   // Stored value with x0 forced to zero and the in-flight write-back forwarded.
   function automatic logic [DATA_WIDTH-1:0] read_bypass(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  wb_en,
      input logic [ADDR_WIDTH-1:0] wb_addr,
      input logic [DATA_WIDTH-1:0] wb_data,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (addr == '0)
         return '0;
      if (wb_en && (wb_addr == addr))
         return wb_data;
      return stored;
   endfunction

   // Decode read ports: zero while in reset or when the port is not enabled.
   assign reg1_rdata_o = (rst_i || !reg1_re_i) ? '0 :
                         read_bypass(reg1_raddr_i, wb_write, reg_waddr_i, reg_wdata_i,
                                     regs[reg1_raddr_i]);
   assign reg2_rdata_o = (rst_i || !reg2_re_i) ? '0 :
                         read_bypass(reg2_raddr_i, wb_write, reg_waddr_i, reg_wdata_i,
                                     regs[reg2_raddr_i]);

   // Register storage; write-back and debug writes are mutually exclusive by construction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         if (wb_write)
            regs[reg_waddr_i] <= reg_wdata_i;
         if (dbg_write)
            regs[dbg_addr_q] <= dbg_wdata_q;
      end
   end

   // Debug access sequencer with registered ack and read data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         dbg_ack_o   <= 1'b0;
         dbg_rdata_o <= '0;
         dbg_we_q    <= 1'b0;
         dbg_addr_q  <= '0;
         dbg_wdata_q <= '0;
      end else begin
         dbg_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (dbg_req_i) begin
                  dbg_we_q    <= dbg_we_i;
                  dbg_addr_q  <= dbg_addr_i;
                  dbg_wdata_q <= dbg_wdata_i;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (dbg_we_q) begin
                  // Write-back owns the write port; no starvation bound.
                  if (!wb_write) begin
                     state     <= ACK;
                     dbg_ack_o <= 1'b1;
                  end
               end else begin
                  dbg_rdata_o <= read_bypass(dbg_addr_q, wb_write, reg_waddr_i, reg_wdata_i,
                                             regs[dbg_addr_q]);
                  state       <= ACK;
                  dbg_ack_o   <= 1'b1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
